// File: rtl/n64_pi_bridge_if.sv
// System signal bundle shared by blocks on the PI side: clock, bridge reset and console resets.
interface if_system;
    logic clk;
    logic reset;
    logic n64_hard_reset;
    logic n64_soft_reset;

    modport sys (
        input clk,
        input reset,
        input n64_hard_reset,
        input n64_soft_reset
    );
endinterface

// File: rtl/n64_pi_bridge.sv
// Converts 16-bit PI request/ack transactions into 32-bit byte-masked memory-bus accesses,
// with a one-word read buffer and a bounded wait on the memory acknowledge.
module n64_pi_bridge #(
    parameter int READ_BUFFER_ENABLE = 1,
    parameter int TIMEOUT_CYCLES     = 1023
) (
    if_system.sys        sys,
    input  logic         pi_request,
    output logic         pi_ack,
    input  logic         pi_write,
    input  logic [31:0]  pi_address,
    input  logic [15:0]  pi_wdata,
    output logic [15:0]  pi_rdata,
    input  logic         invalidate,
    output logic         mem_request,
    input  logic         mem_ack,
    output logic         mem_write,
    output logic [31:0]  mem_address,
    output logic [31:0]  mem_wdata,
    output logic [3:0]   mem_wmask,
    input  logic [31:0]  mem_rdata,
    output logic         timeout
);

    typedef enum logic {S_IDLE, S_MEM} state_t;

    localparam logic [9:0] TIMEOUT_LIM = TIMEOUT_CYCLES[9:0];

    state_t      state, state_nxt;
    logic [31:0] buf_data, buf_data_nxt;
    logic [29:0] buf_tag, buf_tag_nxt;
    logic        buf_valid, buf_valid_nxt;
    logic [9:0]  counter, counter_nxt;
    logic        half_sel, half_sel_nxt;
    logic        inv_seen, inv_seen_nxt;
    logic        pi_ack_nxt, timeout_nxt, mem_request_nxt, mem_write_nxt;
    logic [15:0] pi_rdata_nxt;
    logic [31:0] mem_address_nxt, mem_wdata_nxt;
    logic [3:0]  mem_wmask_nxt;
    logic        inv_any, hit;
    logic        unused_addr_lsb;

    assign unused_addr_lsb = pi_address[0];
    assign inv_any = invalidate | sys.n64_hard_reset | sys.n64_soft_reset;
    assign hit     = (READ_BUFFER_ENABLE != 0) && buf_valid && (buf_tag == pi_address[31:2]);

    // Big-endian: the even halfword lives in the upper 16 bits of the word.
    function automatic logic [15:0] select_half(input logic [31:0] word, input logic low);
        return low ? word[15:0] : word[31:16];
    endfunction

    always_comb begin
        state_nxt       = state;
        pi_ack_nxt      = 1'b0;
        timeout_nxt     = 1'b0;
        pi_rdata_nxt    = pi_rdata;
        mem_request_nxt = mem_request;
        mem_write_nxt   = mem_write;
        mem_address_nxt = mem_address;
        mem_wdata_nxt   = mem_wdata;
        mem_wmask_nxt   = mem_wmask;
        buf_data_nxt    = buf_data;
        buf_tag_nxt     = buf_tag;
        buf_valid_nxt   = buf_valid & ~inv_any;
        counter_nxt     = counter;
        half_sel_nxt    = half_sel;
        inv_seen_nxt    = inv_seen;

        case (state)
            S_IDLE: begin
                if (pi_request) begin
                    if (!pi_write && hit) begin
                        pi_ack_nxt   = 1'b1;
                        pi_rdata_nxt = select_half(buf_data, pi_address[1]);
                    end else begin
                        state_nxt       = S_MEM;
                        mem_request_nxt = 1'b1;
                        mem_write_nxt   = pi_write;
                        mem_address_nxt = {pi_address[31:2], 2'b00};
                        half_sel_nxt    = pi_address[1];
                        counter_nxt     = '0;
                        inv_seen_nxt    = 1'b0;
                        if (pi_write) begin
                            mem_wdata_nxt = {pi_wdata, pi_wdata};
                            mem_wmask_nxt = pi_address[1] ? 4'b0011 : 4'b1100;
                            // Write-through keeps a buffered copy coherent; valid is untouched
                            // so a simultaneous invalidate still wins.
                            if (hit) begin
                                if (pi_address[1]) buf_data_nxt[15:0]  = pi_wdata;
                                else               buf_data_nxt[31:16] = pi_wdata;
                            end
                        end else begin
                            mem_wmask_nxt = 4'hF;
                        end
                    end
                end
            end
            S_MEM: begin
                counter_nxt = counter + 10'd1;
                if (inv_any) inv_seen_nxt = 1'b1;
                if (mem_ack) begin
                    state_nxt       = S_IDLE;
                    mem_request_nxt = 1'b0;
                    pi_ack_nxt      = 1'b1;
                    counter_nxt     = '0;
                    if (!mem_write) begin
                        pi_rdata_nxt  = select_half(mem_rdata, half_sel);
                        buf_data_nxt  = mem_rdata;
                        buf_tag_nxt   = mem_address[31:2];
                        buf_valid_nxt = ~(inv_any | inv_seen);
                    end
                end else if (counter_nxt == TIMEOUT_LIM) begin
                    state_nxt       = S_IDLE;
                    mem_request_nxt = 1'b0;
                    pi_ack_nxt      = 1'b1;
                    timeout_nxt     = 1'b1;
                    counter_nxt     = '0;
                    if (!mem_write) begin
                        pi_rdata_nxt  = 16'hFFFF;
                        buf_valid_nxt = 1'b0;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge sys.clk) begin
        if (sys.reset) begin
            state       <= S_IDLE;
            pi_ack      <= 1'b0;
            pi_rdata    <= '0;
            mem_request <= 1'b0;
            mem_write   <= 1'b0;
            mem_address <= '0;
            mem_wdata   <= '0;
            mem_wmask   <= '0;
            timeout     <= 1'b0;
            buf_valid   <= 1'b0;
            counter     <= '0;
            half_sel    <= 1'b0;
            inv_seen    <= 1'b0;
        end else begin
            state       <= state_nxt;
            pi_ack      <= pi_ack_nxt;
            pi_rdata    <= pi_rdata_nxt;
            mem_request <= mem_request_nxt;
            mem_write   <= mem_write_nxt;
            mem_address <= mem_address_nxt;
            mem_wdata   <= mem_wdata_nxt;
            mem_wmask   <= mem_wmask_nxt;
            timeout     <= timeout_nxt;
            buf_valid   <= buf_valid_nxt;
            counter     <= counter_nxt;
            half_sel    <= half_sel_nxt;
            inv_seen    <= inv_seen_nxt;
        end
    end

    // Buffer payload needs no reset: it is only observed while buf_valid is set.
    always_ff @(posedge sys.clk) begin
        buf_data <= buf_data_nxt;
        buf_tag  <= buf_tag_nxt;
    end

endmodule

// File: tb/tb_n64_pi_bridge.sv
// Bench for n64_pi_bridge: a buffered instance and an unbuffered instance, each with TIMEOUT_CYCLES=8.
module tb_n64_pi_bridge;
    localparam int TO = 8;

    if_system sys_if();

    logic        pi_request, pi_write, invalidate, mem_ack;
    logic [31:0] pi_address, mem_rdata;
    logic [15:0] pi_wdata;
    logic        pi_ack, mem_request, mem_write, timeout;
    logic [15:0] pi_rdata;
    logic [31:0] mem_address, mem_wdata;
    logic [3:0]  mem_wmask;

    logic        b_pi_request, b_pi_write, b_invalidate, b_mem_ack;
    logic [31:0] b_pi_address, b_mem_rdata;
    logic [15:0] b_pi_wdata;
    logic        b_pi_ack, b_mem_request, b_mem_write, b_timeout;
    logic [15:0] b_pi_rdata;
    logic [31:0] b_mem_address, b_mem_wdata;
    logic [3:0]  b_mem_wmask;

    n64_pi_bridge #(.READ_BUFFER_ENABLE(1), .TIMEOUT_CYCLES(TO)) dut (
        .sys(sys_if), .pi_request(pi_request), .pi_ack(pi_ack), .pi_write(pi_write),
        .pi_address(pi_address), .pi_wdata(pi_wdata), .pi_rdata(pi_rdata),
        .invalidate(invalidate), .mem_request(mem_request), .mem_ack(mem_ack),
        .mem_write(mem_write), .mem_address(mem_address), .mem_wdata(mem_wdata),
        .mem_wmask(mem_wmask), .mem_rdata(mem_rdata), .timeout(timeout)
    );

    n64_pi_bridge #(.READ_BUFFER_ENABLE(0), .TIMEOUT_CYCLES(TO)) dut_nobuf (
        .sys(sys_if), .pi_request(b_pi_request), .pi_ack(b_pi_ack), .pi_write(b_pi_write),
        .pi_address(b_pi_address), .pi_wdata(b_pi_wdata), .pi_rdata(b_pi_rdata),
        .invalidate(b_invalidate), .mem_request(b_mem_request), .mem_ack(b_mem_ack),
        .mem_write(b_mem_write), .mem_address(b_mem_address), .mem_wdata(b_mem_wdata),
        .mem_wmask(b_mem_wmask), .mem_rdata(b_mem_rdata), .timeout(b_timeout)
    );

    initial begin
        sys_if.clk = 1'b0;
        forever #5 sys_if.clk = ~sys_if.clk;
    end

    int vectors = 0;
    int miscompares = 0;

    // Reference model: backing memory (word-indexed) and the one-word buffer.
    logic [31:0] mem_model [logic [29:0]];
    bit          bv;
    logic [29:0] btag;
    logic [31:0] bdata;

    function automatic logic [31:0] get_word(input logic [31:0] a);
        logic [29:0] k;
        k = a[31:2];
        if (!mem_model.exists(k)) mem_model[k] = $urandom;
        return mem_model[k];
    endfunction

    function automatic logic [15:0] half_of(input logic [31:0] w, input logic a1);
        return a1 ? w[15:0] : w[31:16];
    endfunction

    task automatic drive_src(input int src, input logic v);
        case (src)
            0:       invalidate = v;
            1:       sys_if.n64_hard_reset = v;
            default: sys_if.n64_soft_reset = v;
        endcase
    endtask

    task automatic pulse_inv(input int src);
        @(negedge sys_if.clk);
        drive_src(src, 1'b1);
        @(negedge sys_if.clk);
        drive_src(src, 1'b0);
    endtask

    // One PI transaction on the buffered instance with a responding memory slave.
    // ack_delay: mem_ack on the Nth cycle of mem_request (0 = never).
    // inv_at: pulse an invalidate source on the Nth mem_request cycle (-1 = with the request).
    task automatic op_a(input bit wr, input logic [31:0] addr, input logic [15:0] wd,
                        input int ack_delay, input int inv_at, input int inv_src,
                        output logic [15:0] rd, output int reqc, output bit to, output bit acked,
                        output logic [31:0] ma, output logic [3:0] mm, output logic [31:0] mw,
                        output logic mwr, output bit stable, output bit req_at_ack,
                        output int lat, output int ack_cyc);
        rd = '0; reqc = 0; to = 0; acked = 0; ma = '0; mm = '0; mw = '0; mwr = 1'b0;
        stable = 1; req_at_ack = 0; lat = 0; ack_cyc = -1;
        @(negedge sys_if.clk);
        pi_request = 1'b1; pi_write = wr; pi_address = addr; pi_wdata = wd;
        if (inv_at == -1) drive_src(inv_src, 1'b1);
        for (int c = 1; c <= 40 && !acked; c++) begin
            @(negedge sys_if.clk);
            pi_request = 1'b0; mem_ack = 1'b0; mem_rdata = $urandom;
            drive_src(inv_src, 1'b0);
            if (pi_ack) begin
                acked = 1; rd = pi_rdata; to = timeout; req_at_ack = mem_request; lat = c;
            end else if (mem_request) begin
                reqc++;
                if (reqc == 1) begin
                    ma = mem_address; mm = mem_wmask; mw = mem_wdata; mwr = mem_write;
                end else if (ma !== mem_address || mm !== mem_wmask || mw !== mem_wdata || mwr !== mem_write) begin
                    stable = 0;
                end
                if (reqc == inv_at) drive_src(inv_src, 1'b1);
                if (reqc == ack_delay) begin
                    mem_ack = 1'b1; mem_rdata = get_word(mem_address); ack_cyc = c;
                end
            end
        end
    endtask

    task automatic b_read(input logic [31:0] addr, output logic [15:0] rd, output int reqc,
                          output logic [3:0] mm, output bit acked);
        rd = '0; reqc = 0; mm = '0; acked = 0;
        @(negedge sys_if.clk);
        b_pi_request = 1'b1; b_pi_write = 1'b0; b_pi_address = addr; b_pi_wdata = '0;
        for (int c = 1; c <= 20 && !acked; c++) begin
            @(negedge sys_if.clk);
            b_pi_request = 1'b0; b_mem_ack = 1'b0;
            if (b_pi_ack) begin
                acked = 1; rd = b_pi_rdata;
            end else if (b_mem_request) begin
                reqc++; mm = b_mem_wmask;
                if (reqc == 1) begin
                    b_mem_ack = 1'b1; b_mem_rdata = get_word(b_mem_address);
                end
            end
        end
    endtask

    task automatic test_reset;
        sys_if.reset = 1'b1;
        repeat (3) @(negedge sys_if.clk);
        vectors++;
        if ({pi_ack, timeout, mem_request, mem_write} !== 4'b0000)
            begin miscompares++; $display("FAIL reset_ctrl: got %b expected 0000", {pi_ack, timeout, mem_request, mem_write}); end
        vectors++;
        if (pi_rdata !== 16'h0 || mem_wmask !== 4'h0)
            begin miscompares++; $display("FAIL reset_rdata_mask: got %h/%h expected 0/0", pi_rdata, mem_wmask); end
        vectors++;
        if (mem_address !== 32'h0 || mem_wdata !== 32'h0)
            begin miscompares++; $display("FAIL reset_addr_wdata: got %h/%h expected 0/0", mem_address, mem_wdata); end
        vectors++;
        if (b_mem_request !== 1'b0 || b_pi_ack !== 1'b0)
            begin miscompares++; $display("FAIL reset_nobuf: got %b%b expected 00", b_mem_request, b_pi_ack); end
        sys_if.reset = 1'b0;
        bv = 0;
    endtask

    task automatic test_read_buffer;
        logic [15:0] rd; int reqc, lat, ackc; bit to, acked, st, rqa;
        logic [31:0] ma, mw; logic [3:0] mm; logic mwr; logic [31:0] a;
        a = 32'h1000_0000;
        mem_model[a[31:2]] = 32'hAABB_CCDD;
        op_a(0, 32'h1000_0000, 16'h0, 2, 0, 0, rd, reqc, to, acked, ma, mm, mw, mwr, st, rqa, lat, ackc);
        vectors++;
        if (!acked || rd !== 16'hAABB)
            begin miscompares++; $display("FAIL miss_rdata: got %h (ack %0d) expected aabb", rd, acked); end
        vectors++;
        if (ma !== 32'h1000_0000 || mm !== 4'hF || mwr !== 1'b0 || reqc != 2)
            begin miscompares++; $display("FAIL miss_bus: got addr %h mask %h wr %b cycles %0d expected 10000000 f 0 2", ma, mm, mwr, reqc); end
        vectors++;
        if (lat != ackc + 1 || rqa || !st)
            begin miscompares++; $display("FAIL miss_timing: got lat %0d ack %0d req %0d stable %0d expected lat ack+1, 0, 1", lat, ackc, rqa, st); end
        op_a(0, 32'h1000_0002, 16'h0, 1, 0, 0, rd, reqc, to, acked, ma, mm, mw, mwr, st, rqa, lat, ackc);
        vectors++;
        if (!acked || rd !== 16'hCCDD || reqc != 0 || lat != 1)
            begin miscompares++; $display("FAIL hit_read: got %h cycles %0d lat %0d expected ccdd 0 1", rd, reqc, lat); end
    endtask

    task automatic test_write_through;
        logic [15:0] rd; int reqc, lat, ackc; bit to, acked, st, rqa;
        logic [31:0] ma, mw; logic [3:0] mm; logic mwr;
        op_a(1, 32'h1000_0002, 16'h1234, 1, 0, 0, rd, reqc, to, acked, ma, mm, mw, mwr, st, rqa, lat, ackc);
        vectors++;
        if (!acked || to || ma !== 32'h1000_0000 || mw !== 32'h1234_1234 || mm !== 4'b0011 || mwr !== 1'b1)
            begin miscompares++; $display("FAIL write_bus: got addr %h data %h mask %b wr %b expected 10000000 12341234 0011 1", ma, mw, mm, mwr); end
        mem_model[30'h0400_0000] = 32'hAABB_1234;
        op_a(0, 32'h1000_0002, 16'h0, 1, 0, 0, rd, reqc, to, acked, ma, mm, mw, mwr, st, rqa, lat, ackc);
        vectors++;
        if (!acked || rd !== 16'h1234 || reqc != 0)
            begin miscompares++; $display("FAIL write_hit_reread: got %h cycles %0d expected 1234 0", rd, reqc); end
        op_a(0, 32'h1000_0000, 16'h0, 1, 0, 0, rd, reqc, to, acked, ma, mm, mw, mwr, st, rqa, lat, ackc);
        vectors++;
        if (!acked || rd !== 16'hAABB || reqc != 0)
            begin miscompares++; $display("FAIL write_other_half: got %h cycles %0d expected aabb 0", rd, reqc); end
    endtask

    task automatic test_no_buffer;
        logic [15:0] rd; int reqc; logic [3:0] mm; bit acked;
        mem_model[30'h0440_0000] = 32'h5566_7788;
        b_read(32'h1100_0000, rd, reqc, mm, acked);
        vectors++;
        if (!acked || rd !== 16'h5566 || reqc != 1 || mm !== 4'hF)
            begin miscompares++; $display("FAIL nobuf_first: got %h cycles %0d mask %h expected 5566 1 f", rd, reqc, mm); end
        b_read(32'h1100_0002, rd, reqc, mm, acked);
        vectors++;
        if (!acked || rd !== 16'h7788 || reqc != 1 || mm !== 4'hF)
            begin miscompares++; $display("FAIL nobuf_second: got %h cycles %0d mask %h expected 7788 1 f", rd, reqc, mm); end
    endtask

    task automatic test_timeout;
        logic [15:0] rd; int reqc, lat, ackc; bit to, acked, st, rqa, seen;
        logic [31:0] ma, mw; logic [3:0] mm; logic mwr;
        mem_model[30'h0800_0000] = 32'h0102_0304;
        op_a(0, 32'h2000_0000, 16'h0, 1, 0, 0, rd, reqc, to, acked, ma, mm, mw, mwr, st, rqa, lat, ackc);
        op_a(0, 32'h2000_0006, 16'h0, 0, 0, 0, rd, reqc, to, acked, ma, mm, mw, mwr, st, rqa, lat, ackc);
        vectors++;
        if (!acked || !to || rd !== 16'hFFFF)
            begin miscompares++; $display("FAIL timeout_ack: got ack %0d to %0d rdata %h expected 1 1 ffff", acked, to, rd); end
        vectors++;
        if (reqc < TO || reqc > TO + 1 || rqa)
            begin miscompares++; $display("FAIL timeout_len: got %0d request cycles (req at ack %0d) expected %0d..%0d, 0", reqc, rqa, TO, TO + 1); end
        @(negedge sys_if.clk);
        mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        seen = 0;
        repeat (4) begin
            @(negedge sys_if.clk);
            mem_ack = 1'b0;
            if (pi_ack || mem_request || timeout) seen = 1;
        end
        vectors++;
        if (seen)
            begin miscompares++; $display("FAIL late_ack: got activity 1 expected 0"); end
        op_a(0, 32'h2000_0000, 16'h0, 1, 0, 0, rd, reqc, to, acked, ma, mm, mw, mwr, st, rqa, lat, ackc);
        vectors++;
        if (!acked || reqc != 1 || rd !== 16'h0102 || to)
            begin miscompares++; $display("FAIL after_timeout_miss: got %h cycles %0d to %0d expected 0102 1 0", rd, reqc, to); end
    endtask

    task automatic test_invalidate;
        logic [15:0] rd; int reqc, lat, ackc; bit to, acked, st, rqa;
        logic [31:0] ma, mw; logic [3:0] mm; logic mwr;
        mem_model[30'h0840_0000] = 32'hCAFE_F00D;
        op_a(0, 32'h2100_0000, 16'h0, 3, 1, 0, rd, reqc, to, acked, ma, mm, mw, mwr, st, rqa, lat, ackc);
        vectors++;
        if (!acked || rd !== 16'hCAFE)
            begin miscompares++; $display("FAIL inv_fill_data: got %h expected cafe", rd); end
        op_a(0, 32'h2100_0002, 16'h0, 1, 0, 0, rd, reqc, to, acked, ma, mm, mw, mwr, st, rqa, lat, ackc);
        vectors++;
        if (!acked || reqc != 1 || rd !== 16'hF00D)
            begin miscompares++; $display("FAIL inv_fill_refetch: got %h cycles %0d expected f00d 1", rd, reqc); end
        for (int src = 1; src <= 2; src++) begin
            pulse_inv(src);
            op_a(0, 32'h2100_0000, 16'h0, 1, 0, 0, rd, reqc, to, acked, ma, mm, mw, mwr, st, rqa, lat, ackc);
            vectors++;
            if (!acked || reqc != 1 || rd !== 16'hCAFE)
                begin miscompares++; $display("FAIL console_reset_inv%0d: got %h cycles %0d expected cafe 1", src, rd, reqc); end
        end
        op_a(1, 32'h2100_0002, 16'hBEEF, 1, -1, 0, rd, reqc, to, acked, ma, mm, mw, mwr, st, rqa, lat, ackc);
        mem_model[30'h0840_0000] = 32'hCAFE_BEEF;
        op_a(0, 32'h2100_0000, 16'h0, 1, 0, 0, rd, reqc, to, acked, ma, mm, mw, mwr, st, rqa, lat, ackc);
        vectors++;
        if (!acked || reqc != 1 || rd !== 16'hCAFE)
            begin miscompares++; $display("FAIL inv_beats_write_hit: got %h cycles %0d expected cafe 1", rd, reqc); end
        op_a(0, 32'h2100_0002, 16'h0, 1, 0, 0, rd, reqc, to, acked, ma, mm, mw, mwr, st, rqa, lat, ackc);
        vectors++;
        if (!acked || reqc != 0 || rd !== 16'hBEEF)
            begin miscompares++; $display("FAIL refill_hit: got %h cycles %0d expected beef 0", rd, reqc); end
    endtask

    task automatic test_reset_inflight;
        logic [15:0] rd; int reqc, lat, ackc; bit to, acked, st, rqa, seen;
        logic [31:0] ma, mw; logic [3:0] mm; logic mwr;
        op_a(0, 32'h2200_0000, 16'h0, 1, 0, 0, rd, reqc, to, acked, ma, mm, mw, mwr, st, rqa, lat, ackc);
        @(negedge sys_if.clk);
        pi_request = 1'b1; pi_write = 1'b0; pi_address = 32'h2200_0004;
        repeat (3) begin
            @(negedge sys_if.clk);
            pi_request = 1'b0;
        end
        vectors++;
        if (mem_request !== 1'b1)
            begin miscompares++; $display("FAIL reset_pre_request: got %b expected 1", mem_request); end
        sys_if.reset = 1'b1;
        @(negedge sys_if.clk);
        sys_if.reset = 1'b0;
        vectors++;
        if (mem_request !== 1'b0 || mem_wmask !== 4'h0 || mem_address !== 32'h0)
            begin miscompares++; $display("FAIL reset_drop: got req %b mask %h addr %h expected 0 0 0", mem_request, mem_wmask, mem_address); end
        seen = 0;
        repeat (8) begin
            @(negedge sys_if.clk);
            if (pi_ack || mem_request) seen = 1;
        end
        vectors++;
        if (seen)
            begin miscompares++; $display("FAIL reset_no_ack: got activity 1 expected 0"); end
        op_a(0, 32'h2200_0000, 16'h0, 1, 0, 0, rd, reqc, to, acked, ma, mm, mw, mwr, st, rqa, lat, ackc);
        vectors++;
        if (!acked || reqc != 1 || rd !== half_of(get_word(32'h2200_0000), 1'b0))
            begin miscompares++; $display("FAIL reset_buffer_invalid: got %h cycles %0d expected miss", rd, reqc); end
    endtask

    task automatic test_random;
        logic [15:0] rd, wd, exp; int reqc, lat, ackc, dly, inv_at, src; bit to, acked, st, rqa, h, wr;
        logic [31:0] ma, mw, addr, w; logic [3:0] mm, expm; logic mwr;
        pulse_inv(0);
        bv = 0;
        for (int i = 0; i < 80; i++) begin
            addr   = 32'h3000_0000 | (32'($urandom_range(0, 3)) << 2) | (32'($urandom_range(0, 1)) << 1);
            wr     = ($urandom_range(0, 9) < 3);
            wd     = 16'($urandom);
            dly    = int'($urandom_range(1, 4));
            inv_at = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, dly)) : 0;
            src    = int'($urandom_range(0, 2));
            if ($urandom_range(0, 7) == 0) begin
                pulse_inv(src);
                bv = 0;
            end
            h = bv && (btag == addr[31:2]);
            w = get_word(addr);
            op_a(wr, addr, wd, dly, inv_at, src, rd, reqc, to, acked, ma, mm, mw, mwr, st, rqa, lat, ackc);
            if (!wr) begin
                exp = half_of(h ? bdata : w, addr[1]);
                vectors++;
                if (!acked || rd !== exp)
                    begin miscompares++; $display("FAIL rand_read[%0d]: addr %h got %h expected %h", i, addr, rd, exp); end
                vectors++;
                if (reqc != (h ? 0 : dly))
                    begin miscompares++; $display("FAIL rand_read_bus[%0d]: addr %h got %0d cycles expected %0d", i, addr, reqc, h ? 0 : dly); end
                if (!h) begin
                    vectors++;
                    if (ma !== {addr[31:2], 2'b00} || mm !== 4'hF || mwr !== 1'b0 || !st)
                        begin miscompares++; $display("FAIL rand_read_req[%0d]: got %h %h %b stable %0d", i, ma, mm, mwr, st); end
                    bdata = w; btag = addr[31:2]; bv = (inv_at == 0);
                end
            end else begin
                expm = addr[1] ? 4'b0011 : 4'b1100;
                vectors++;
                if (!acked || to || reqc != dly)
                    begin miscompares++; $display("FAIL rand_write_ack[%0d]: got ack %0d to %0d cycles %0d expected 1 0 %0d", i, acked, to, reqc, dly); end
                vectors++;
                if (ma !== {addr[31:2], 2'b00} || mm !== expm || mw !== {wd, wd} || mwr !== 1'b1 || !st)
                    begin miscompares++; $display("FAIL rand_write_req[%0d]: got %h %b %h %b expected %h %b %h 1", i, ma, mm, mw, mwr, {addr[31:2], 2'b00}, expm, {wd, wd}); end
                if (addr[1]) w[15:0] = wd;
                else         w[31:16] = wd;
                mem_model[addr[31:2]] = w;
                if (h) bdata = w;
                if (inv_at != 0) bv = 0;
            end
        end
    endtask

    initial begin
        pi_request = 0; pi_write = 0; pi_address = '0; pi_wdata = '0; invalidate = 0;
        mem_ack = 0; mem_rdata = '0;
        b_pi_request = 0; b_pi_write = 0; b_pi_address = '0; b_pi_wdata = '0; b_invalidate = 0;
        b_mem_ack = 0; b_mem_rdata = '0;
        sys_if.reset = 1'b1; sys_if.n64_hard_reset = 1'b0; sys_if.n64_soft_reset = 1'b0;
        test_reset();
        test_read_buffer();
        test_write_through();
        test_no_buffer();
        test_timeout();
        test_invalidate();
        test_reset_inflight();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/n64_pi_bridge.md
Name: n64_pi_bridge

Overview:
Sits directly downstream of the N64 PI bus front-end. It consumes that block's 16-bit single-outstanding request/ack transactions and converts them into 32-bit byte-masked accesses on the internal memory bus. A one-word read buffer serves the second halfword of a 32-bit word without a bus access. A timeout counter guarantees every PI request is acknowledged.

Parameters:
READ_BUFFER_ENABLE, 1, 1 = enable one-word read buffer; 0 = every read goes to the memory bus.
TIMEOUT_CYCLES, 1023, memory-bus cycles to wait for mem_ack before aborting; legal range 1..1023.

Ports:
sys.clk  input  1  clock (via if_system.sys modport).
sys.reset  input  1  synchronous, active-high reset (via if_system.sys modport).
sys.n64_hard_reset / sys.n64_soft_reset  input  1  N64 console resets; used only to invalidate the buffer.
pi_request  input  1  one-cycle request pulse from the PI front-end.
pi_ack  output  1  one-cycle acknowledge pulse.
pi_write  input  1  1 = write, 0 = read; valid with pi_request.
pi_address  input  32  byte address; bit 0 is always 0.
pi_wdata  input  16  write halfword.
pi_rdata  output  16  read halfword; valid when pi_ack is high.
invalidate  input  1  pulse that clears the read buffer (another master wrote memory).
mem_request  output  1  level; held until mem_ack or timeout.
mem_ack  input  1  one-cycle completion from memory.
mem_write  output  1  1 = write access.
mem_address  output  32  word address; bits [1:0] always 0.
mem_wdata  output  32  write data.
mem_wmask  output  4  byte enables; bit 3 = bits [31:24].
mem_rdata  input  32  read data; valid with mem_ack.
timeout  output  1  one-cycle pulse when an access is aborted.

Behaviour:
- Reset values: pi_ack=0, pi_rdata=0, mem_request=0, mem_write=0, mem_address=0, mem_wdata=0, mem_wmask=0, timeout=0, state=S_IDLE, buffer valid=0, counter=0.
- Byte order is big-endian:
  - pi_address[1]=0 selects word bits [31:16], mask 4'b1100.
  - pi_address[1]=1 selects word bits [15:0], mask 4'b0011.
- Buffer contents: data[31:0], tag = address[31:2], valid bit.
- Hit = READ_BUFFER_ENABLE && valid && tag == pi_address[31:2].
- States are S_IDLE and S_MEM.
- S_IDLE, pi_request, read hit:
  - pi_ack=1 and pi_rdata = selected half on the next cycle.
  - No bus access; state stays S_IDLE.
- S_IDLE, pi_request, read miss:
  - Next cycle: mem_request=1, mem_write=0, mem_address={pi_address[31:2],2'b00}, mem_wmask=4'hF.
  - Enter S_MEM.
- S_IDLE, pi_request, write:
  - Next cycle: mem_request=1, mem_write=1, mem_wdata={pi_wdata,pi_wdata}, mem_wmask as selected by pi_address[1].
  - Enter S_MEM.
  - On a hit, the matching buffer half is updated immediately (write-through).
- S_MEM:
  - The counter increments each cycle.
  - mem_ack sampled high: next cycle mem_request=0, pi_ack=1, state S_IDLE.
  - For a read, on that same next cycle pi_rdata = selected half of mem_rdata; buffer loads mem_rdata, the tag, and valid=1.
  - Read latency: 1 cycle after mem_ack.
  - Counter reaching TIMEOUT_CYCLES with no mem_ack: next cycle mem_request=0, pi_ack=1, timeout=1, state S_IDLE.
  - On timeout, a read returns pi_rdata=16'hFFFF and the buffer is invalidated.
- pi_request arriving while in S_MEM is ignored; upstream guarantees one outstanding request.
- mem_ack arriving in S_IDLE (late ack after a timeout) is ignored.
- invalidate, n64_hard_reset or n64_soft_reset:
  - Clear valid on the next cycle.
  - If asserted during an S_MEM read, the fill still returns data to the PI side but leaves valid=0.
  - These inputs never abort an in-flight memory access.
- invalidate in the same cycle as a write-hit update: valid=0 wins.
- sys.reset in any state:
  - Next cycle: all outputs at their reset values, state S_IDLE, in-flight access dropped with no pi_ack.
- mem_address/mem_wdata/mem_wmask/mem_write are stable while mem_request=1.

Test Plan:
- Read 0x1000_0000 (miss): mem_address=0x1000_0000, mem_rdata=0xAABB_CCDD → pi_rdata=0xAABB; then read 0x1000_0002 → pi_ack 1 cycle after the request, pi_rdata=0xCCDD, no mem_request.
- Write 0x1234 to 0x1000_0002 after the fill above → mem_wdata=0x1234_1234, mem_wmask=4'b0011; re-read 0x1000_0002 hits and returns 0x1234.
- Same two reads with READ_BUFFER_ENABLE=0 → two memory reads, both mem_wmask=4'hF.
- TIMEOUT_CYCLES=8, mem_ack never asserted → mem_request drops, pi_ack and timeout pulse, pi_rdata=0xFFFF; a late mem_ack is ignored and the next read misses.
- invalidate pulsed during a miss fill → pi_rdata correct, and a following read of the same word issues a new mem_request.
- sys.reset asserted while mem_request=1 → next cycle mem_request=0, pi_ack never pulses, buffer invalid.
